// File: rtl/loop_controller_pkg.sv
// Shared types for the BeeF loop controller and its fetch/datapath neighbours.
// Optional build macro used by the top: LOOP_CTRL_STATS_EN.
package loop_controller_pkg;

    typedef logic [15:0] PROGRAM_COUNTER;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_INC_PTR,
        OP_DEC_PTR,
        OP_INC_DATA,
        OP_DEC_DATA,
        OP_OUTPUT,
        OP_INPUT,
        OP_LOOP_OPEN,
        OP_LOOP_CLOSE,
        OP_HALT
    } op_code;

    typedef enum logic {
        PC_INCREMENTED,
        PC_LOADED
    } PC_SRC;

    typedef enum logic {
        DISABLE,
        ENABLE
    } CONTROL;

    typedef enum logic [1:0] {
        LOOP_RUN,
        LOOP_SCAN,
        LOOP_FAULT
    } loop_state_t;

    localparam int LOOP_STACK_DEPTH = 16;

    // Wraps modulo 2^16 by construction of the return width.
    function automatic PROGRAM_COUNTER pc_next(input PROGRAM_COUNTER p);
        return p + 16'd1;
    endfunction

endpackage

// File: rtl/loop_controller_if.sv
// Fetch-side bundle between fetch_unit and loop_controller.
// master = fetch/datapath side, slave = loop_controller.
interface loop_controller_if;
    import loop_controller_pkg::*;

    op_code         instruction;
    PROGRAM_COUNTER pc;
    logic           data_zero;
    logic           stall;
    PC_SRC          pc_src;
    CONTROL         pc_write;
    PROGRAM_COUNTER pc_loaded;
    logic           exec_en;

    modport master (
        output instruction,
        output pc,
        output data_zero,
        output stall,
        input  pc_src,
        input  pc_write,
        input  pc_loaded,
        input  exec_en
    );

    modport slave (
        input  instruction,
        input  pc,
        input  data_zero,
        input  stall,
        output pc_src,
        output pc_write,
        output pc_loaded,
        output exec_en
    );

endinterface

// File: rtl/loop_controller_stack.sv
// Return-address LIFO for active loops; async reset empties it.
// Overflow/underflow requests are ignored here and flagged by the caller.
module loop_stack #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] tp_idx;

    assign wr_idx = AW'(cnt);
    assign tp_idx = AW'(cnt - CW'(1));
    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    assign top    = mem[tp_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Storage needs no reset: entries above cnt are never read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/loop_controller.sv
// Loop sequencer for BeeF: backward jumps via a return stack, forward scan on zero.
// Define LOOP_CTRL_STATS_EN to add the saturating jump_count output.
module loop_controller
    import loop_controller_pkg::*;
#(
    parameter int STACK_DEPTH = LOOP_STACK_DEPTH,
    parameter int SCAN_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    loop_controller_if.slave   bus,
`ifdef LOOP_CTRL_STATS_EN
    output logic [15:0]        jump_count,
`endif
    output logic               fault
);

    loop_state_t     state;
    loop_state_t     state_nxt;
    logic [SCAN_W-1:0] depth;
    logic [SCAN_W-1:0] depth_nxt;

    logic            push;
    logic            pop;
    PROGRAM_COUNTER  top;
    logic            full;
    logic            empty;
    logic            is_open;
    logic            is_close;

    assign is_open  = (bus.instruction == OP_LOOP_OPEN);
    assign is_close = (bus.instruction == OP_LOOP_CLOSE);
    assign fault    = (state == LOOP_FAULT);

    loop_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (16)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.pc),
        .top   (top),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOOP_RUN;
            depth <= '0;
        end else begin
            state <= state_nxt;
            depth <= depth_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        depth_nxt     = depth;
        push          = 1'b0;
        pop           = 1'b0;
        bus.pc_src    = PC_INCREMENTED;
        bus.pc_loaded = '0;
        bus.pc_write  = DISABLE;
        bus.exec_en   = 1'b0;

        unique case (state)
            LOOP_RUN: begin
                bus.exec_en = 1'b1;
                if (!bus.stall) begin
                    bus.pc_write = ENABLE;
                    unique case (1'b1)
                        is_open: begin
                            if (bus.data_zero) begin
                                depth_nxt = SCAN_W'(1);
                                state_nxt = LOOP_SCAN;
                            end else if (full) begin
                                state_nxt = LOOP_FAULT;
                            end else begin
                                push = 1'b1;
                            end
                        end
                        is_close: begin
                            // No valid target on an empty stack: just step and fault.
                            if (empty) begin
                                state_nxt = LOOP_FAULT;
                            end else if (!bus.data_zero) begin
                                bus.pc_src    = PC_LOADED;
                                bus.pc_loaded = pc_next(top);
                            end else begin
                                pop = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            LOOP_SCAN: begin
                bus.pc_write = ENABLE;
                unique case (1'b1)
                    is_open: begin
                        if (depth == '1) begin
                            state_nxt = LOOP_FAULT;
                        end else begin
                            depth_nxt = depth + SCAN_W'(1);
                        end
                    end
                    is_close: begin
                        if (depth == SCAN_W'(1)) begin
                            depth_nxt = '0;
                            state_nxt = LOOP_RUN;
                        end else begin
                            depth_nxt = depth - SCAN_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
            LOOP_FAULT: ;
            default: state_nxt = LOOP_FAULT;
        endcase

        // Reset is async, so outputs must go quiet in the same cycle.
        if (reset) begin
            push          = 1'b0;
            pop           = 1'b0;
            bus.pc_src    = PC_INCREMENTED;
            bus.pc_loaded = '0;
            bus.pc_write  = DISABLE;
            bus.exec_en   = 1'b0;
        end
    end

`ifdef LOOP_CTRL_STATS_EN
    logic jump;

    assign jump = (bus.pc_write == ENABLE) && (bus.pc_src == PC_LOADED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jump_count <= '0;
        end else if (jump && (jump_count != '1)) begin
            jump_count <= jump_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_loop_controller.sv
// Scoreboard bench for loop_controller with a behavioural fetch_unit model.
// Define LOOP_CTRL_STATS_EN to also exercise jump_count.
module tb_loop_controller;
    import loop_controller_pkg::*;

    typedef struct {
        string          nm;
        PROGRAM_COUNTER pc;
        CONTROL         we;
        PC_SRC          src;
        PROGRAM_COUNTER ld;
        logic           en;
        logic           flt;
        logic           emp;
        logic [7:0]     dep;
        logic           xo;
        logic           xp;
        logic           cj;
        logic [15:0]    jc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic fault;
    logic ld;
    PROGRAM_COUNTER ld_val;
    PROGRAM_COUNTER pc_q;
    op_code prog [256];
    exp_t sb [$];
    int n_cmp = 0;
    int n_bad = 0;
`ifdef LOOP_CTRL_STATS_EN
    logic [15:0] jump_count;
`endif

    loop_controller_if lif ();

    always #5 clk = ~clk;

    assign lif.pc          = pc_q;
    assign lif.instruction = prog[pc_q[7:0]];

    loop_controller u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (lif.slave),
`ifdef LOOP_CTRL_STATS_EN
        .jump_count (jump_count),
`endif
        .fault      (fault)
    );

    // fetch_unit model
    always @(posedge clk) begin
        if (ld) begin
            pc_q <= ld_val;
        end else if (lif.pc_write == ENABLE) begin
            pc_q <= (lif.pc_src == PC_LOADED) ? lif.pc_loaded : pc_q + 16'd1;
        end
    end

    task automatic chk(input string nm, input string f,
                       input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h want %0h", nm, f, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (!e.xp) chk(e.nm, "pc", 32'(lif.pc), 32'(e.pc));
            if (!e.xo) begin
                chk(e.nm, "pc_write", 32'(lif.pc_write), 32'(e.we));
                chk(e.nm, "pc_src", 32'(lif.pc_src), 32'(e.src));
                chk(e.nm, "pc_loaded", 32'(lif.pc_loaded), 32'(e.ld));
            end
            chk(e.nm, "exec_en", 32'(lif.exec_en), 32'(e.en));
            chk(e.nm, "fault", 32'(fault), 32'(e.flt));
            chk(e.nm, "empty", 32'(u_dut.u_stack.empty), 32'(e.emp));
            chk(e.nm, "depth", 32'(u_dut.depth), 32'(e.dep));
`ifdef LOOP_CTRL_STATS_EN
            if (e.cj) chk(e.nm, "jump_count", 32'(jump_count), 32'(e.jc));
`endif
        end
    end

    task automatic step(input string nm, input logic r, input logic dz,
                        input logic st, input PROGRAM_COUNTER pc,
                        input CONTROL we, input PC_SRC src,
                        input PROGRAM_COUNTER ldv, input logic en,
                        input logic flt, input logic emp, input int dep,
                        input logic xo = 1'b0, input logic xp = 1'b0,
                        input logic cj = 1'b0, input logic [15:0] jc = '0);
        exp_t e;
        reset         = r;
        lif.data_zero = dz;
        lif.stall     = st;
        e = '{nm, pc, we, src, ldv, en, flt, emp, 8'(dep), xo, xp, cj, jc};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        foreach (prog[i]) prog[i] = OP_NOP;
        prog[8'h00] = OP_LOOP_OPEN;
        prog[8'h01] = OP_INC_DATA;
        prog[8'h02] = OP_LOOP_CLOSE;
        prog[8'h04] = OP_LOOP_OPEN;
        prog[8'h05] = OP_LOOP_CLOSE;
        prog[8'h10] = OP_LOOP_OPEN;
        prog[8'h11] = OP_LOOP_OPEN;
        prog[8'h12] = OP_INC_DATA;
        prog[8'h13] = OP_LOOP_CLOSE;
        prog[8'h14] = OP_INC_DATA;
        prog[8'h15] = OP_LOOP_CLOSE;
        prog[8'h3F] = OP_LOOP_OPEN;
        for (int i = 0; i < 17; i++) prog[8'h80 + i] = OP_LOOP_OPEN;
        prog[8'hA0] = OP_LOOP_CLOSE;
        prog[8'hC0] = OP_LOOP_OPEN;
        prog[8'hC1] = OP_LOOP_CLOSE;

        reset = 1'b1;
        lif.data_zero = 1'b0;
        lif.stall = 1'b0;
        ld = 1'b0;
        ld_val = '0;
        pc_q = '0;
        repeat (2) @(posedge clk);
        #1;
        step("rst", 1, 0, 0, 16'h0, DISABLE, PC_INCREMENTED, 0, 0, 0, 1, 0);

        // "[+]" : two taken loops, then exit
        step("a_open", 0, 0, 0, 16'h0, ENABLE, PC_INCREMENTED, 0, 1, 0, 1, 0);
        step("a_inc1", 0, 0, 0, 16'h1, ENABLE, PC_INCREMENTED, 0, 1, 0, 0, 0);
        step("a_jmp1", 0, 0, 0, 16'h2, ENABLE, PC_LOADED, 16'h1, 1, 0, 0, 0);
        step("a_inc2", 0, 0, 0, 16'h1, ENABLE, PC_INCREMENTED, 0, 1, 0, 0, 0);
        step("a_jmp2", 0, 0, 0, 16'h2, ENABLE, PC_LOADED, 16'h1, 1, 0, 0, 0);
        step("a_inc3", 0, 0, 0, 16'h1, ENABLE, PC_INCREMENTED, 0, 1, 0, 0, 0);
        step("a_exit", 0, 1, 0, 16'h2, ENABLE, PC_INCREMENTED, 0, 1, 0, 0, 0);
        step("a_post", 0, 0, 0, 16'h3, ENABLE, PC_INCREMENTED, 0, 1, 0, 1, 0);

        // stall held on a taken close
        step("s_open", 0, 0, 0, 16'h4, ENABLE, PC_INCREMENTED, 0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            step("s_stall", 0, 0, 1, 16'h5, DISABLE, PC_INCREMENTED, 0, 1, 0, 0, 0);
        step("s_jmp", 0, 0, 0, 16'h5, ENABLE, PC_LOADED, 16'h5, 1, 0, 0, 0);
        step("s_exit", 0, 1, 0, 16'h5, ENABLE, PC_INCREMENTED, 0, 1, 0, 0, 0);
        ld = 1'b1;
        ld_val = 16'h10;
        step("s_post", 0, 0, 0, 16'h6, ENABLE, PC_INCREMENTED, 0, 1, 0, 1, 0);
        ld = 1'b0;

        // "[[+]+]" skipped by forward scan
        step("f_open", 0, 1, 0, 16'h10, ENABLE, PC_INCREMENTED, 0, 1, 0, 1, 0);
        step("f_11", 0, 1, 0, 16'h11, ENABLE, PC_INCREMENTED, 0, 0, 0, 1, 1);
        step("f_12", 0, 1, 1, 16'h12, ENABLE, PC_INCREMENTED, 0, 0, 0, 1, 2);
        step("f_13", 0, 1, 0, 16'h13, ENABLE, PC_INCREMENTED, 0, 0, 0, 1, 2);
        step("f_14", 0, 1, 0, 16'h14, ENABLE, PC_INCREMENTED, 0, 0, 0, 1, 1);
        step("f_15", 0, 1, 0, 16'h15, ENABLE, PC_INCREMENTED, 0, 0, 0, 1, 1);
        ld = 1'b1;
        ld_val = 16'h3F;
        step("f_16", 0, 0, 0, 16'h16, ENABLE, PC_INCREMENTED, 0, 1, 0, 1, 0);
        ld = 1'b0;

        // reset asserted mid-scan at pc 0x40
        step("r_open", 0, 1, 0, 16'h3F, ENABLE, PC_INCREMENTED, 0, 1, 0, 1, 0);
        step("r_hit", 1, 0, 0, 16'h40, DISABLE, PC_INCREMENTED, 0, 0, 0, 1, 0);
        step("r_hold", 1, 0, 0, 16'h40, DISABLE, PC_INCREMENTED, 0, 0, 0, 1, 0);
        ld = 1'b1;
        ld_val = 16'h80;
        step("r_run", 0, 0, 0, 16'h40, ENABLE, PC_INCREMENTED, 0, 1, 0, 1, 0);
        ld = 1'b0;

        // 17 nested taken opens overflow the stack
        for (int i = 0; i < 16; i++)
            step("n_push", 0, 0, 0, 16'(16'h80 + i), ENABLE, PC_INCREMENTED,
                 0, 1, 0, (i == 0), 0);
        step("n_17", 0, 0, 0, 16'h90, ENABLE, PC_INCREMENTED, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++)
            step("n_flt", 0, 0, 0, 16'h0, DISABLE, PC_INCREMENTED, 0, 0, 1, 0, 0, 0, 1);
        ld = 1'b1;
        ld_val = 16'hA0;
        step("n_rst", 1, 0, 0, 16'h0, DISABLE, PC_INCREMENTED, 0, 0, 0, 1, 0, 0, 1);
        ld = 1'b0;

        // close on an empty stack
        step("e_close", 0, 0, 0, 16'hA0, ENABLE, PC_INCREMENTED, 0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 2; i++)
            step("e_flt", 0, 0, 0, 16'h0, DISABLE, PC_INCREMENTED, 0, 0, 1, 1, 0, 0, 1);
        ld = 1'b1;
        ld_val = 16'hC0;
        step("e_rst", 1, 0, 0, 16'h0, DISABLE, PC_INCREMENTED, 0, 0, 0, 1, 0, 0, 1);
        ld = 1'b0;

`ifdef LOOP_CTRL_STATS_EN
        step("j_open", 0, 0, 0, 16'hC0, ENABLE, PC_INCREMENTED, 0, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            step("j_jmp", 0, 0, 0, 16'hC1, ENABLE, PC_LOADED, 16'hC1, 1, 0, 0, 0);
        step("j_cnt5", 0, 0, 1, 16'hC1, DISABLE, PC_INCREMENTED, 0, 1, 0, 0, 0,
             0, 0, 1, 16'd5);
        force u_dut.jump_count = 16'hFFFF;
        #1;
        release u_dut.jump_count;
        step("j_sat", 0, 0, 0, 16'hC1, ENABLE, PC_LOADED, 16'hC1, 1, 0, 0, 0);
        step("j_cntff", 0, 0, 1, 16'hC1, DISABLE, PC_INCREMENTED, 0, 1, 0, 0, 0,
             0, 0, 1, 16'hFFFF);
`endif

        repeat (2) @(negedge clk);
        chk("end", "sb_left", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
